// File: rtl/intra_pkg.sv
// Shared intra-prediction definitions: H.264 intra4x4 mode codes, scheduler states
// and the directional-mode index to mode-code lookup.
package intra_pkg;

  localparam int NUM_MODES_4X4 = 8;

  typedef logic [3:0] intra4x4_mode_t;

  localparam intra4x4_mode_t MODE_V   = 4'd0;
  localparam intra4x4_mode_t MODE_H   = 4'd1;
  localparam intra4x4_mode_t MODE_DDL = 4'd3;
  localparam intra4x4_mode_t MODE_DDR = 4'd4;
  localparam intra4x4_mode_t MODE_VR  = 4'd5;
  localparam intra4x4_mode_t MODE_HD  = 4'd6;
  localparam intra4x4_mode_t MODE_VL  = 4'd7;
  localparam intra4x4_mode_t MODE_HU  = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE, ST_PRED, ST_RES, ST_COST, ST_EMIT, ST_DONE
  } sched_state_t;

  // DC (code 2) is not among the evaluated directional modes, hence the gap.
  function automatic intra4x4_mode_t mode_code(input logic [2:0] idx);
    case (idx)
      3'd0:    mode_code = MODE_V;
      3'd1:    mode_code = MODE_H;
      3'd2:    mode_code = MODE_DDL;
      3'd3:    mode_code = MODE_DDR;
      3'd4:    mode_code = MODE_VR;
      3'd5:    mode_code = MODE_HD;
      3'd6:    mode_code = MODE_VL;
      default: mode_code = MODE_HU;
    endcase
  endfunction

endpackage

// File: rtl/intra_argmin8.sv
// Combinational argmin over N unsigned costs; ties resolve to the lowest index.
// Built as a heap-ordered binary tree, so N must be a power of two.
module intra_argmin8 #(
  parameter  int N  = 8,
  parameter  int W  = 16,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0][W-1:0] cost,
  output logic [IW-1:0]       win_idx,
  output logic [W-1:0]        win_cost
);

  // Node j has children 2j+1 (lower indices) and 2j+2; leaf for index m sits at N-1+m.
  logic [W-1:0]  nc [2*N-1];
  logic [IW-1:0] ni [2*N-1];

  for (genvar m = 0; m < N; m++) begin : g_leaf
    assign nc[N-1+m] = cost[m];
    assign ni[N-1+m] = IW'(m);
  end

  // Right child wins only on strictly smaller cost, which keeps the lowest index on ties.
  for (genvar j = 0; j < N-1; j++) begin : g_node
    logic take_r;
    assign take_r = nc[2*j+2] < nc[2*j+1];
    assign nc[j]  = take_r ? nc[2*j+2] : nc[2*j+1];
    assign ni[j]  = take_r ? ni[2*j+2] : ni[2*j+1];
  end

  assign win_idx  = ni[0];
  assign win_cost = nc[0];

endmodule

// File: rtl/intra4x4_mode_sched.sv
// Intra 4x4 per-macroblock scheduler: sequences predictor/residual enables for the
// 16 luma blocks, picks the cheapest mode per block and hands it downstream.
import intra_pkg::*;

module intra4x4_mode_sched #(
  parameter int PRED_LAT  = 2,
  parameter int COST_W    = 16,
  parameter int NUM_MODES = NUM_MODES_4X4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  output logic                        busy,
  output logic [3:0]                  blk_idx,
  output logic                        pred_en,
  output logic                        res_en,
  input  logic                        cost_valid,
  input  logic [NUM_MODES*COST_W-1:0] cost,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [3:0]                  out_blk,
  output logic [3:0]                  out_mode,
  output logic [COST_W-1:0]           out_cost,
  output logic                        done,
  output logic [COST_W+3:0]           mb_cost
);

  localparam logic [3:0] PRED_LAST = 4'(PRED_LAT - 1);

  sched_state_t        state, nxt;
  logic [3:0]          cnt;
  logic [2:0]          win_idx;
  logic [COST_W-1:0]   win_cost;
  logic [COST_W+3:0]   acc;

  intra_argmin8 #(.N(NUM_MODES), .W(COST_W)) u_argmin (
    .cost     (cost),
    .win_idx  (win_idx),
    .win_cost (win_cost)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      blk_idx  <= '0;
      cnt      <= '0;
      out_blk  <= '0;
      out_mode <= MODE_V;
      out_cost <= '0;
      acc      <= '0;
    end else begin
      state <= nxt;
      case (state)
        ST_IDLE: if (start) begin
          blk_idx <= '0;
          cnt     <= '0;
          acc     <= '0;
        end
        ST_PRED: cnt <= (cnt == PRED_LAST) ? 4'd0 : cnt + 4'd1;
        ST_COST: if (cost_valid) begin
          out_blk  <= blk_idx;
          out_mode <= mode_code(win_idx);
          out_cost <= win_cost;
          acc      <= acc + {4'b0, win_cost};
        end
        ST_EMIT: if (out_ready && blk_idx != 4'd15) blk_idx <= blk_idx + 4'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: if (start)                nxt = ST_PRED;
      ST_PRED: if (cnt == PRED_LAST)     nxt = ST_RES;
      ST_RES:                            nxt = ST_COST;
      ST_COST: if (cost_valid)           nxt = ST_EMIT;
      ST_EMIT: if (out_ready)            nxt = (blk_idx == 4'd15) ? ST_DONE : ST_PRED;
      ST_DONE:                           nxt = ST_IDLE;
      default:                           nxt = ST_IDLE;
    endcase
  end

  assign busy      = state != ST_IDLE;
  assign pred_en   = (state == ST_PRED) && (cnt == 4'd0);
  assign res_en    = state == ST_RES;
  assign out_valid = state == ST_EMIT;
  assign done      = state == ST_DONE;
  assign mb_cost   = acc;

endmodule

// File: tb/tb_intra4x4_mode_sched.sv
// Directed bench for intra4x4_mode_sched: table of per-block cost vectors with
// hand-computed winners, plus backpressure, stray-input, abort and DONE sequences.
module tb_intra4x4_mode_sched;

  localparam int PRED_LAT = 2;
  localparam int COST_W   = 16;
  localparam int NM       = 8;

  logic                   clk = 1'b0;
  logic                   reset, start, cost_valid, out_ready;
  logic [NM*COST_W-1:0]   cost;
  logic                   busy, pred_en, res_en, out_valid, done;
  logic [3:0]             blk_idx, out_blk, out_mode;
  logic [COST_W-1:0]      out_cost;
  logic [COST_W+3:0]      mb_cost;

  intra4x4_mode_sched #(.PRED_LAT(PRED_LAT), .COST_W(COST_W), .NUM_MODES(NM)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .blk_idx(blk_idx),
    .pred_en(pred_en), .res_en(res_en), .cost_valid(cost_valid), .cost(cost),
    .out_valid(out_valid), .out_ready(out_ready), .out_blk(out_blk),
    .out_mode(out_mode), .out_cost(out_cost), .done(done), .mb_cost(mb_cost)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec  = 0;
  int nfail = 0;

  typedef struct {
    logic [7:0][15:0] c;
    int               exp_mode;
    int               exp_cost;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mkv(int a0, int a1, int a2, int a3, int a4, int a5,
                               int a6, int a7, int em, int ec);
    vec_t v;
    v.c[0] = 16'(a0); v.c[1] = 16'(a1); v.c[2] = 16'(a2); v.c[3] = 16'(a3);
    v.c[4] = 16'(a4); v.c[5] = 16'(a5); v.c[6] = 16'(a6); v.c[7] = 16'(a7);
    v.exp_mode = em;
    v.exp_cost = ec;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, " busy"},      busy,      0);
    chk({tag, " blk_idx"},   blk_idx,   0);
    chk({tag, " pred_en"},   pred_en,   0);
    chk({tag, " res_en"},    res_en,    0);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " out_blk"},   out_blk,   0);
    chk({tag, " out_mode"},  out_mode,  0);
    chk({tag, " out_cost"},  out_cost,  0);
    chk({tag, " done"},      done,      0);
    chk({tag, " mb_cost"},   mb_cost,   0);
  endtask

  // Entered on the first PRED cycle of block k; leaves on the cycle after the handshake.
  task automatic run_block(input int k, input logic [7:0][15:0] c, input int em,
                           input int ec, input int bp, input bit stray,
                           input int cdelay, input bit abort);
    chk("pred_en at block start", pred_en, 1);
    chk("blk_idx at block start", blk_idx, k);
    if (stray) begin
      cost_valid = 1'b1;
      cost       = {8{16'h0001}};
      start      = 1'b1;
      out_ready  = 1'b1;
    end
    for (int i = 1; i < PRED_LAT; i++) begin
      step();
      chk("pred_en single pulse", pred_en, 0);
      chk("res_en in PRED", res_en, 0);
      chk("blk_idx in PRED", blk_idx, k);
    end
    step();
    chk("res_en pulse", res_en, 1);
    chk("pred_en in RES", pred_en, 0);
    step();
    cost_valid = 1'b0;
    start      = 1'b0;
    out_ready  = 1'b0;
    chk("res_en single pulse", res_en, 0);
    chk("out_valid in COST", out_valid, 0);
    chk("busy in COST", busy, 1);
    for (int i = 0; i < cdelay; i++) begin
      step();
      chk("COST waits for cost_valid", out_valid, 0);
    end
    if (abort) begin
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk_idle_reset("abort");
      step();
      chk("no done after abort", done, 0);
      chk("idle after abort", busy, 0);
      return;
    end
    cost_valid = 1'b1;
    cost       = c;
    step();
    cost_valid = 1'b0;
    cost       = {8{16'h0002}};
    chk("out_valid", out_valid, 1);
    chk("out_blk", out_blk, k);
    chk("out_mode", out_mode, em);
    chk("out_cost", out_cost, ec);
    for (int i = 0; i < bp; i++) begin
      cost_valid = 1'b1;
      step();
      chk("bp out_valid held", out_valid, 1);
      chk("bp out_mode stable", out_mode, em);
      chk("bp out_cost stable", out_cost, ec);
      chk("bp out_blk stable", out_blk, k);
      chk("bp no pred_en", pred_en, 0);
      chk("bp blk_idx held", blk_idx, k);
    end
    cost_valid = 1'b0;
    out_ready  = 1'b1;
    step();
    out_ready  = 1'b0;
  endtask

  task automatic run_mb(input bit use_tbl, input logic [15:0] cval, input int bp_blk,
                        input int stray_blk, input int delay_blk, input int abort_blk,
                        input bit chk_lat);
    logic [7:0][15:0] cc;
    int em, ec, c0;
    longint exp_sum;
    chk("idle before start", busy, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    c0 = cyc;
    chk("busy after start", busy, 1);
    chk("mb_cost cleared at start", mb_cost, 0);
    exp_sum = 0;
    for (int k = 0; k < 16; k++) begin
      if (use_tbl) begin
        cc = tbl[k].c; em = tbl[k].exp_mode; ec = tbl[k].exp_cost;
      end else begin
        for (int m = 0; m < 8; m++) cc[m] = cval;
        em = 0; ec = int'(cval);
      end
      run_block(k, cc, em, ec, (k == bp_blk) ? 7 : 0, k == stray_blk,
                (k == delay_blk) ? 3 : 0, k == abort_blk);
      if (k == abort_blk) return;
      exp_sum += ec;
    end
    chk("done pulse", done, 1);
    chk("mb_cost at done", mb_cost, exp_sum[31:0]);
    chk("busy during DONE", busy, 1);
    if (chk_lat) chk("first PRED to done cycles", cyc - c0 + 1, 16*(PRED_LAT+3)+1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("done single pulse", done, 0);
    chk("busy drops after DONE", busy, 0);
    step();
    chk("start in DONE ignored", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, nvec=%0d", nvec);
    $fatal(1);
  end

  initial begin
    tbl[0]  = mkv(5, 5, 5, 5, 5, 5, 5, 5,                     0, 5);
    tbl[1]  = mkv(9, 3, 7, 8, 9, 9, 9, 9,                     1, 3);
    tbl[2]  = mkv(9, 9, 2, 8, 9, 9, 9, 9,                     3, 2);
    tbl[3]  = mkv(50, 40, 40, 90, 10, 10, 70, 20,             5, 10);
    tbl[4]  = mkv(9, 9, 9, 1, 9, 9, 9, 9,                     4, 1);
    tbl[5]  = mkv(9, 9, 9, 9, 9, 4, 9, 9,                     6, 4);
    tbl[6]  = mkv(9, 9, 9, 9, 9, 9, 6, 9,                     7, 6);
    tbl[7]  = mkv(9, 9, 9, 9, 9, 9, 9, 7,                     8, 7);
    tbl[8]  = mkv(0, 0, 0, 0, 0, 0, 0, 0,                     0, 0);
    tbl[9]  = mkv(65535, 65534, 65535, 65535, 65535, 65535, 65535, 65534, 1, 65534);
    tbl[10] = mkv(300, 200, 100, 50, 50, 100, 200, 0,         8, 0);
    tbl[11] = mkv(8, 8, 8, 8, 8, 8, 3, 3,                     7, 3);
    tbl[12] = mkv(1000, 999, 998, 997, 996, 995, 994, 993,    8, 993);
    tbl[13] = mkv(993, 994, 995, 996, 997, 998, 999, 1000,    0, 993);
    tbl[14] = mkv(40000, 30000, 20000, 10000, 20000, 30000, 40000, 50000, 4, 10000);
    tbl[15] = mkv(7, 7, 7, 2, 2, 7, 2, 7,                     4, 2);

    reset = 1'b1; start = 1'b0; cost_valid = 1'b0; out_ready = 1'b0; cost = '0;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk_idle_reset("reset");

    run_mb(1'b0, 16'd100, -1, -1, -1, -1, 1'b1);
    chk("mb_cost 16x100 retained", mb_cost, 1600);
    run_mb(1'b1, 16'd0, 3, 5, 7, -1, 1'b0);
    run_mb(1'b0, 16'hFFFF, -1, -1, -1, -1, 1'b1);
    chk("mb_cost max no wrap", mb_cost, 32'hFFFF0);
    run_mb(1'b1, 16'd0, -1, -1, -1, 9, 1'b0);
    run_mb(1'b1, 16'd0, -1, -1, -1, -1, 1'b1);
    chk("mb_cost after restart", mb_cost, 77563);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
